ub_arbiter: RTL and testbench
=============================

UB_ARBITER -- requirements
Module: ub_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (0 host MMIO, 1 control/MOVE, 2 result writeback).
REQ-002 Parameter LOCK_MAX, default 16, maximum consecutive locked grants to one requester.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester access request, held until granted.
REQ-006 wr_en  input  NUM_REQ  per-requester write (1) / read (0) qualifier.
REQ-007 lock  input  NUM_REQ  per-requester request to keep grant on following cycles.
REQ-008 addr  input  NUM_REQ*`ADDR_WIDTH  packed per-requester addresses, requester i at slice i.
REQ-009 wdata  input  NUM_REQ*`BUFFER_WIDTH  packed per-requester write data.
REQ-010 gnt  output  NUM_REQ  one-hot-or-zero grant, same cycle as access.
REQ-011 rvalid  output  NUM_REQ  one-hot-or-zero read-data-valid, one cycle after read grant.
REQ-012 rdata  output  `BUFFER_WIDTH  read data broadcast to all requesters.
REQ-013 ub_req, ub_wr_en  output  1 each  Unified Buffer access strobe and write enable.
REQ-014 ub_addr  output  `ADDR_WIDTH; ub_wdata  output  `BUFFER_WIDTH  Unified Buffer address/data.
REQ-015 ub_rdata  input  `BUFFER_WIDTH  Unified Buffer read data, valid one cycle after read strobe.

Function
REQ-016 Grant SHALL be combinational from req and registered state; at most one gnt bit high per cycle.
REQ-017 No req high: gnt=0, ub_req=0, ub_wr_en=0, ub_addr=0, ub_wdata=0.
REQ-018 Granted requester i drives ub_req=1, ub_wr_en=wr_en[i], ub_addr=addr slice i, ub_wdata=wdata slice i in the same cycle.
REQ-019 Unlocked arbitration SHALL be round-robin: search starts at pointer rr_ptr, wrapping NUM_REQ-1 to 0.
REQ-020 After any grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ; rr_ptr unchanged on idle cycles.
REQ-021 Granted with lock[i]=1 sets lock_valid=1, lock_owner=i, lock_cnt=1.
REQ-022 While lock_valid and req[lock_owner]=1 and lock_cnt<LOCK_MAX, the owner SHALL win regardless of rr_ptr; lock_cnt increments per grant.
REQ-023 Lock released when owner deasserts req or lock (that cycle arbitrates round-robin), or lock_cnt reaches LOCK_MAX (next cycle forced round-robin with owner lowest priority).
REQ-024 Read grant to i SHALL assert rvalid[i] exactly the next cycle with rdata=ub_rdata; writes produce no rvalid.
REQ-025 Back-to-back read grants SHALL produce back-to-back rvalid; no read is dropped or reordered.
REQ-026 rdata SHALL equal ub_rdata every cycle; only rvalid qualifies it.
REQ-027 Requester dropping req before grant is legal; no state changes for it.

Reset
REQ-028 rst_n low SHALL asynchronously clear rr_ptr=0, lock_valid=0, lock_owner=0, lock_cnt=0, rvalid=0.
REQ-029 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release.
REQ-030 First post-reset arbitration SHALL prefer requester 0.

Configuration
REQ-031 Macro UB_ARB_HOST_PRIO_EN defined: requester 0 SHALL win over all others, including an active lock (lock held but not granted, lock_cnt unchanged); requesters 1..NUM_REQ-1 round-robin among themselves.
REQ-032 UB_ARB_HOST_PRIO_EN undefined: all requesters equal under REQ-019..REQ-023.

Verification
REQ-033 After reset, req=3'b111 all reads, held 3 cycles -> gnt 001,010,100; rvalid 001,010,100 one cycle delayed each.
REQ-034 Requester 1 write addr 0x0010 data 0xA5.., then requester 2 read 0x0010 -> ub_wr_en=1 at 0x0010, then rvalid[2]=1 with rdata 0xA5...
REQ-035 Requester 1 req+lock held 20 cycles, requester 2 req constant -> gnt[1] for 16 cycles, gnt[2] at cycle 17, LOCK_MAX enforced.
REQ-036 Requester 1 locked, drops lock at cycle 4 with requester 0 pending -> gnt[0] at cycle 4, rr_ptr=1.
REQ-037 rst_n pulsed low the cycle after a read grant to 2 -> rvalid stays 0, rr_ptr=0 after release.
REQ-038 With UB_ARB_HOST_PRIO_EN, requester 1 locked, requester 0 req one cycle -> gnt[0] that cycle, gnt[1] resumes next cycle.

Source files
------------

// File: rtl/ub_arbiter_if.sv
// ub_arbiter_if: requester-side and Unified Buffer-side bus bundle for ub_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the Unified Buffer.
// ADDR_WIDTH and BUFFER_WIDTH fall back to 16 and 32 bits when not defined
// elsewhere in the build.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

interface ub_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]               req;
   logic [NUM_REQ-1:0]               wr_en;
   logic [NUM_REQ-1:0]               lock;
   logic [NUM_REQ*`ADDR_WIDTH-1:0]   addr;
   logic [NUM_REQ*`BUFFER_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]               gnt;
   logic [NUM_REQ-1:0]               rvalid;
   logic [`BUFFER_WIDTH-1:0]         rdata;
   logic                             ub_req;
   logic                             ub_wr_en;
   logic [`ADDR_WIDTH-1:0]           ub_addr;
   logic [`BUFFER_WIDTH-1:0]         ub_wdata;
   logic [`BUFFER_WIDTH-1:0]         ub_rdata;

   modport slave (
      input  req, wr_en, lock, addr, wdata, ub_rdata,
      output gnt, rvalid, rdata, ub_req, ub_wr_en, ub_addr, ub_wdata
   );

   modport master (
      output req, wr_en, lock, addr, wdata, ub_rdata,
      input  gnt, rvalid, rdata, ub_req, ub_wr_en, ub_addr, ub_wdata
   );
endinterface

// File: rtl/ub_arbiter.sv
// ub_arbiter: single-port Unified Buffer arbiter for NUM_REQ requesters
// (0 host MMIO, 1 control/MOVE, 2 result writeback).
// Grant is combinational and the winning requester's access is forwarded to
// the buffer in the same cycle. Unlocked arbitration is round-robin; a granted
// requester holding lock keeps the buffer for up to LOCK_MAX consecutive grants.
// Optional feature macro: UB_ARB_HOST_PRIO_EN -- requester 0 beats everyone,
// including an active lock, and the rest round-robin among themselves.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH 32
`endif

module ub_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int LOCK_MAX = 16
) (
   input logic         clk,
   input logic         rst_n,
   ub_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   typedef logic [IDX_W-1:0] idx_t;

   idx_t               r_rrPtr;
   idx_t               r_lockOwner;
   logic               r_lockValid;
   logic [CNT_W-1:0]   r_lockCnt;
   logic [NUM_REQ-1:0] r_rvalid;

   logic               w_lockWin;
   logic               w_ownerHolding;
   logic               w_hostWin;
   logic               w_hostKeep;
   logic               w_rrFound;
   logic               w_anyGnt;
   idx_t               w_rrIdx;
   idx_t               w_gntIdx;
   idx_t               w_nextPtr;
   logic [NUM_REQ-1:0] w_rrMask;
   logic [NUM_REQ-1:0] w_gnt;

   // The owner still wants the buffer and still asks to keep it
   assign w_ownerHolding = bus.req[r_lockOwner] && bus.lock[r_lockOwner];
   assign w_lockWin      = r_lockValid && w_ownerHolding &&
                           (r_lockCnt < CNT_W'(LOCK_MAX));

`ifdef UB_ARB_HOST_PRIO_EN
   // Host takes the buffer outright; the others share round-robin, and a lock
   // pre-empted by the host survives untouched
   assign w_hostWin  = bus.req[0];
   assign w_rrMask   = bus.req & ~NUM_REQ'(1);
   assign w_hostKeep = w_hostWin && r_lockValid && (r_lockOwner != '0) &&
                       w_ownerHolding;
`else
   assign w_hostWin  = 1'b0;
   assign w_rrMask   = bus.req;
   assign w_hostKeep = 1'b0;
`endif

   // Round-robin search starting at the pointer and wrapping past the top index
   always_comb begin
      w_rrFound = 1'b0;
      w_rrIdx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_rrFound && w_rrMask[(int'(r_rrPtr) + k) % NUM_REQ]) begin
            w_rrFound = 1'b1;
            w_rrIdx   = idx_t'((int'(r_rrPtr) + k) % NUM_REQ);
         end
      end
   end

   // Winner selection: host priority (if built in), then lock owner, then round-robin
   always_comb begin
      w_anyGnt = 1'b0;
      w_gntIdx = '0;
      if (w_hostWin) begin
         w_anyGnt = 1'b1;
         w_gntIdx = '0;
      end else if (w_lockWin) begin
         w_anyGnt = 1'b1;
         w_gntIdx = r_lockOwner;
      end else if (w_rrFound) begin
         w_anyGnt = 1'b1;
         w_gntIdx = w_rrIdx;
      end
   end

   assign w_gnt     = w_anyGnt ? (NUM_REQ'(1) << w_gntIdx) : '0;
   assign w_nextPtr = (int'(w_gntIdx) == NUM_REQ - 1) ? '0 : w_gntIdx + idx_t'(1);

   assign bus.gnt      = w_gnt;
   assign bus.ub_req   = w_anyGnt;
   assign bus.ub_wr_en = w_anyGnt && bus.wr_en[w_gntIdx];
   assign bus.ub_addr  = w_anyGnt ?
                         bus.addr[int'(w_gntIdx)*`ADDR_WIDTH +: `ADDR_WIDTH] : '0;
   assign bus.ub_wdata = w_anyGnt ?
                         bus.wdata[int'(w_gntIdx)*`BUFFER_WIDTH +: `BUFFER_WIDTH] : '0;
   assign bus.rdata    = bus.ub_rdata;
   assign bus.rvalid   = r_rvalid;

   // Arbitration state: pointer advance, lock bookkeeping and one-cycle read-valid pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rrPtr     <= '0;
         r_lockValid <= 1'b0;
         r_lockOwner <= '0;
         r_lockCnt   <= '0;
         r_rvalid    <= '0;
      end else begin
         r_rvalid <= w_gnt & ~bus.wr_en;
         if (w_anyGnt) begin
            r_rrPtr <= w_nextPtr;
            if (!w_hostKeep) begin
               if (bus.lock[w_gntIdx]) begin
                  if (w_lockWin && (w_gntIdx == r_lockOwner)) begin
                     r_lockCnt <= r_lockCnt + CNT_W'(1);
                  end else begin
                     r_lockValid <= 1'b1;
                     r_lockOwner <= w_gntIdx;
                     r_lockCnt   <= CNT_W'(1);
                  end
               end else begin
                  r_lockValid <= 1'b0;
                  r_lockCnt   <= '0;
               end
            end
         end else if (r_lockValid && !w_ownerHolding) begin
            r_lockValid <= 1'b0;
            r_lockCnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ub_arbiter.sv
// tb_ub_arbiter: directed self-checking bench for ub_arbiter with a small
// Unified Buffer memory model answering reads one cycle after the strobe.

module tb_ub_arbiter;

   localparam int NR = 3;
   localparam int AW = `ADDR_WIDTH;
   localparam int BW = `BUFFER_WIDTH;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [BW-1:0] ubMem [0:255];

   ub_arbiter_if #(.NUM_REQ(NR)) bus ();

   ub_arbiter #(.NUM_REQ(NR), .LOCK_MAX(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unified Buffer model: writes land on the edge, reads return on the next cycle
   always @(posedge clk) begin
      if (bus.ub_req) begin
         if (bus.ub_wr_en) ubMem[bus.ub_addr[7:0]] <= bus.ub_wdata;
         else              bus.ub_rdata <= ubMem[bus.ub_addr[7:0]];
      end
   end

   task automatic setLane(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
      bus.addr[i*AW +: AW]  = a;
      bus.wdata[i*BW +: BW] = d;
   endtask

   task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] w,
                                input logic [NR-1:0] l);
      @(posedge clk);
      #1;
      bus.req   = r;
      bus.wr_en = w;
      bus.lock  = l;
      #3;
   endtask

   task automatic doReset;
      rst_n     = 1'b0;
      bus.req   = '0;
      bus.wr_en = '0;
      bus.lock  = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      bus.req   = '0;
      bus.wr_en = '0;
      bus.lock  = '0;
      setLane(0, 16'h0055, 32'h1111_1111);
      setLane(1, 16'h0066, 32'h2222_2222);
      setLane(2, 16'h0077, 32'h3333_3333);
      @(posedge clk);
      #3;
      total++; if (bus.rvalid !== 3'b000) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 000", bus.rvalid); end
      total++; if (bus.gnt !== 3'b000) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 000", bus.gnt); end
      total++; if (bus.ub_req !== 1'b0 || bus.ub_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL idle_strobe: got req=%b wr=%b want 0 0", bus.ub_req, bus.ub_wr_en); end
      total++; if (bus.ub_addr !== '0 || bus.ub_wdata !== '0) begin bad++; $display("[TB] FAIL idle_bus: got addr=%h data=%h want 0 0", bus.ub_addr, bus.ub_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin;
      logic [NR-1:0] expG [0:4];
      logic [NR-1:0] expV [0:4];
      logic [BW-1:0] expD [0:4];
`ifdef UB_ARB_HOST_PRIO_EN
      expG = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
      expV = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      expD = '{32'h0, 32'hC000_0001, 32'hC000_0001, 32'hC000_0001, 32'h0};
`else
      expG = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
      expV = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
      expD = '{32'h0, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'h0};
`endif
      doReset();
      setLane(0, 16'h0001, '0);
      setLane(1, 16'h0002, '0);
      setLane(2, 16'h0003, '0);
      for (int c = 0; c < 5; c++) begin
         applyStimulus((c < 3) ? 3'b111 : 3'b000, 3'b000, 3'b000);
         total++; if (bus.gnt !== expG[c]) begin bad++; $display("[TB] FAIL rr_gnt c%0d: got %b want %b", c, bus.gnt, expG[c]); end
         total++; if (bus.rvalid !== expV[c]) begin bad++; $display("[TB] FAIL rr_rvalid c%0d: got %b want %b", c, bus.rvalid, expV[c]); end
         if (expV[c] != 3'b000) begin
            total++; if (bus.rdata !== expD[c]) begin bad++; $display("[TB] FAIL rr_rdata c%0d: got %h want %h", c, bus.rdata, expD[c]); end
         end
      end
   endtask

   task automatic test_write_read;
      setLane(1, 16'h0010, 32'hA5A5_A5A5);
      setLane(2, 16'h0010, 32'h0000_0000);
      applyStimulus(3'b010, 3'b010, 3'b000);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL wr_gnt: got %b want 010", bus.gnt); end
      total++; if (bus.ub_req !== 1'b1 || bus.ub_wr_en !== 1'b1) begin bad++; $display("[TB] FAIL wr_strobe: got req=%b wr=%b want 1 1", bus.ub_req, bus.ub_wr_en); end
      total++; if (bus.ub_addr !== 16'h0010 || bus.ub_wdata !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL wr_bus: got addr=%h data=%h want 0010 a5a5a5a5", bus.ub_addr, bus.ub_wdata); end
      applyStimulus(3'b100, 3'b000, 3'b000);
      total++; if (bus.gnt !== 3'b100 || bus.ub_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL rd_gnt: got gnt=%b wr=%b want 100 0", bus.gnt, bus.ub_wr_en); end
      total++; if (bus.ub_addr !== 16'h0010) begin bad++; $display("[TB] FAIL rd_addr: got %h want 0010", bus.ub_addr); end
      total++; if (bus.rvalid !== 3'b000) begin bad++; $display("[TB] FAIL wr_no_rvalid: got %b want 000", bus.rvalid); end
      applyStimulus(3'b000, 3'b000, 3'b000);
      total++; if (bus.rvalid !== 3'b100) begin bad++; $display("[TB] FAIL rd_rvalid: got %b want 100", bus.rvalid); end
      total++; if (bus.rdata !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL rd_rdata: got %h want a5a5a5a5", bus.rdata); end
      total++; if (bus.ub_req !== 1'b0 || bus.ub_addr !== '0 || bus.ub_wdata !== '0) begin bad++; $display("[TB] FAIL idle_after_rd: got req=%b addr=%h data=%h want 0", bus.ub_req, bus.ub_addr, bus.ub_wdata); end
   endtask

   task automatic test_lock_max;
      logic [NR-1:0] exp;
      doReset();
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(3'b110, 3'b110, 3'b010);
         exp = (c == 17) ? 3'b100 : 3'b010;
         total++; if (bus.gnt !== exp) begin bad++; $display("[TB] FAIL lock_max_gnt c%0d: got %b want %b", c, bus.gnt, exp); end
      end
      applyStimulus(3'b000, 3'b000, 3'b000);
   endtask

`ifdef UB_ARB_HOST_PRIO_EN
   task automatic test_host_prio;
      doReset();
      applyStimulus(3'b110, 3'b110, 3'b010);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL host_c1: got %b want 010", bus.gnt); end
      applyStimulus(3'b111, 3'b111, 3'b010);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("[TB] FAIL host_preempt: got %b want 001", bus.gnt); end
      applyStimulus(3'b110, 3'b110, 3'b010);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL host_resume: got %b want 010", bus.gnt); end
      applyStimulus(3'b110, 3'b110, 3'b010);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL host_lock_kept: got %b want 010", bus.gnt); end
      applyStimulus(3'b000, 3'b000, 3'b000);
   endtask
`else
   task automatic test_lock_release;
      doReset();
      applyStimulus(3'b010, 3'b011, 3'b010);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL rel_c1: got %b want 010", bus.gnt); end
      applyStimulus(3'b011, 3'b011, 3'b010);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL rel_c2_locked: got %b want 010", bus.gnt); end
      applyStimulus(3'b011, 3'b011, 3'b010);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL rel_c3_locked: got %b want 010", bus.gnt); end
      applyStimulus(3'b011, 3'b011, 3'b000);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("[TB] FAIL rel_c4_gnt0: got %b want 001", bus.gnt); end
      applyStimulus(3'b111, 3'b111, 3'b000);
      total++; if (bus.gnt !== 3'b010) begin bad++; $display("[TB] FAIL rel_ptr_after: got %b want 010", bus.gnt); end
      applyStimulus(3'b000, 3'b000, 3'b000);
   endtask
`endif

   task automatic test_reset_mid_read;
      setLane(0, 16'h0001, '0);
      setLane(2, 16'h0003, '0);
      applyStimulus(3'b001, 3'b000, 3'b000);
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("[TB] FAIL rst_pre_gnt: got %b want 001", bus.gnt); end
      applyStimulus(3'b100, 3'b000, 3'b000);
      total++; if (bus.gnt !== 3'b100) begin bad++; $display("[TB] FAIL rst_rd_gnt: got %b want 100", bus.gnt); end
      @(negedge clk);
      rst_n   = 1'b0;
      bus.req = '0;
      @(posedge clk);
      #3;
      total++; if (bus.rvalid !== 3'b000) begin bad++; $display("[TB] FAIL rst_in_rvalid: got %b want 000", bus.rvalid); end
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(3'b111, 3'b000, 3'b000);
      total++; if (bus.rvalid !== 3'b000) begin bad++; $display("[TB] FAIL rst_post_rvalid: got %b want 000", bus.rvalid); end
      total++; if (bus.gnt !== 3'b001) begin bad++; $display("[TB] FAIL rst_ptr_zero: got %b want 001", bus.gnt); end
      applyStimulus(3'b000, 3'b000, 3'b000);
      total++; if (bus.rvalid !== 3'b001) begin bad++; $display("[TB] FAIL rst_first_rvalid: got %b want 001", bus.rvalid); end
   endtask

   // Sequence every scenario, then report totals
   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      bus.req      = '0;
      bus.wr_en    = '0;
      bus.lock     = '0;
      bus.addr     = '0;
      bus.wdata    = '0;
      bus.ub_rdata = '0;
      for (int k = 0; k < 256; k++) ubMem[k] = 32'hC000_0000 | BW'(k);
      $display("[TB] starting ub_arbiter bench");
      test_reset();
      test_round_robin();
      test_write_read();
      test_lock_max();
`ifdef UB_ARB_HOST_PRIO_EN
      test_host_prio();
`else
      test_lock_release();
`endif
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
